// File: rtl/pipe_stage.sv
// pipe_stage: generic pipeline register stage with a valid/ready handshake,
// synchronous flush and zero-control bubbles.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined     -> main slot plus one skid slot (occupancy 0..2); in_ready is
//                  a decode of the state register only, so there is no
//                  combinational path from out_ready to in_ready.
//   not defined -> main slot only (occupancy 0..1); in_ready = !out_valid | out_ready.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both high. The producer holds valid and the payload stable until
// that edge. Valid does not depend on ready; ready may depend on valid.
//
// State is visible on the occupancy output. The encoding is EMPTY=0,
// FULL=1 and SKID=2, which equals the number of beats held.
module pipe_stage #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic              load_main;
  logic              in_xfer;
  logic              out_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              load_skid;
  logic              skid_to_main;
`endif

  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = 2'(state_q);
  assign out_data  = main_data_q;
  // An empty slot can never carry live control bits downstream.
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = (state_q != S_SKID);
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_EMPTY;
    else          state_q <= state_d;
  end

  // Next-state and slot-load decode. Flush beats every other transition.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
`endif
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d   = S_FULL;
            load_main = 1'b1;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            if (in_xfer) load_main = 1'b1;
            else         state_d   = S_EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_xfer) begin
            state_d   = S_SKID;
            load_skid = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        S_SKID: begin
          if (out_xfer) begin
            state_d      = S_FULL;
            skid_to_main = 1'b1;
          end
        end
`endif
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Main slot: takes a new beat, or the skid beat when the head drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main) begin
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (skid_to_main) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
`endif
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid slot: catches the beat that arrives while the head is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= in_ctrl;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed bench for pipe_stage with a FIFO model of the
// held beats and literal spot checks.
module tb_pipe_stage;
  localparam int DATA_W = 69;
  localparam int CTRL_W = 4;
  localparam int BW     = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush = 1'b0;
  logic [1:0]        occupancy;

  pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .occupancy(occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: FIFO of held beats {ctrl,data} ----------------
  logic [BW-1:0] exp_q[$];

  function automatic logic model_ready();
    if (CAP == 2) return exp_q.size() < 2;
    else          return (exp_q.size() == 0) || out_ready;
  endfunction

  always @(posedge clk) begin
    if (reset_n) begin
      logic ix, ox;
      ix = in_valid && model_ready();
      ox = (exp_q.size() > 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (ox) void'(exp_q.pop_front());
        if (ix) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  always @(negedge reset_n) exp_q.delete();

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      logic [BW-1:0] head;
      int sz;
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : '0;
      chk("out_valid", out_valid, sz > 0);
      chk("occupancy", occupancy, sz);
      chk("in_ready", in_ready, model_ready());
      chk("out_ctrl", out_ctrl, head[BW-1:DATA_W]);
      if (sz > 0) chk("out_data", out_data, head[DATA_W-1:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  logic [DATA_W-1:0] big_a = 69'h1A_5A5A_5A5A_0000_0001;
  logic [DATA_W-1:0] big_b = 69'h05_0F0F_0F0F_F0F0_0002;
  logic [DATA_W-1:0] big_d = 69'h1F_FFFF_FFFF_FFFF_FFFD;
  logic [9:0] iv_pat = 10'b1101110111;
  logic [9:0] or_pat = 10'b0110011011;

  initial begin
    // Reset state without any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst0_valid", out_valid, 1'b0);
    chk("rst0_data", out_data, '0);
    chk("rst0_ctrl", out_ctrl, '0);
    chk("rst0_occ", occupancy, 2'd0);
    chk("rst0_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Streaming: 8 beats, out_ready high, one-cycle latency, no gaps.
    for (int i = 1; i <= 9; i++) begin
      step(i <= 8, DATA_W'(i), 4'b1011, 1'b1, 1'b0);
      #3;
      if (i > 1) begin
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_data", out_data, i - 1);
        chk("stream_ctrl", out_ctrl, 4'b1011);
      end
    end
    idle(1'b1);
    #3 chk("stream_drained", out_valid, 1'b0);

    // Simultaneous in and out while FULL: beat replaced 1:1.
    step(1'b1, big_a, 4'b0110, 1'b1, 1'b0);
    step(1'b1, big_d, 4'b0001, 1'b1, 1'b0);
    #3;
    chk("swap_occ", occupancy, 2'd1);
    chk("swap_head_a", out_data, big_a);
    idle(1'b0);
    #3;
    chk("swap_head_d", out_data, big_d);
    chk("swap_ctrl_d", out_ctrl, 4'b0001);
    chk("swap_occ2", occupancy, 2'd1);
    idle(1'b1);
    idle(1'b0);
    #3 chk("swap_drained", out_valid, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
    // Back-pressure fills the skid slot; release drains in order.
    step(1'b1, big_a, 4'b1100, 1'b0, 1'b0);
    step(1'b1, big_b, 4'b0011, 1'b0, 1'b0);
    idle(1'b0);
    #3;
    chk("skid_occ", occupancy, 2'd2);
    chk("skid_in_ready", in_ready, 1'b0);
    chk("skid_head_a", out_data, big_a);
    idle(1'b1);
    #3 chk("skid_first_a", out_data, big_a);
    idle(1'b1);
    #3;
    chk("skid_then_b", out_data, big_b);
    chk("skid_ctrl_b", out_ctrl, 4'b0011);
    chk("skid_ready_back", in_ready, 1'b1);
    idle(1'b0);
    #3 chk("skid_drained", out_valid, 1'b0);
`else
    // Without skid: in_ready follows out_ready combinationally.
    step(1'b1, big_a, 4'b1100, 1'b0, 1'b0);
    step(1'b1, big_b, 4'b0011, 1'b0, 1'b0);
    #3;
    chk("noskid_ready_low", in_ready, 1'b0);
    chk("noskid_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1 chk("noskid_ready_comb", in_ready, 1'b1);
    idle(1'b0);
    #3;
    chk("noskid_replaced", out_data, big_b);
    chk("noskid_occ", occupancy, 2'd1);
    idle(1'b1);
    idle(1'b0);
    #3 chk("noskid_drained", out_valid, 1'b0);
`endif

    // Flush with the stage filled plus an incoming beat C.
    step(1'b1, DATA_W'(32'hA), 4'b1111, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    step(1'b1, DATA_W'(32'hB), 4'b1111, 1'b0, 1'b0);
`endif
    step(1'b1, DATA_W'(32'hC), 4'b1010, 1'b0, 1'b1);
    idle(1'b0);
    #3;
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ctrl", out_ctrl, 4'b0000);
    idle(1'b1);
    #3 chk("flush_no_c", out_valid, 1'b0);

    // Flush while the head leaves and a new beat arrives: new beat dropped.
    step(1'b1, DATA_W'(32'hE), 4'b1001, 1'b1, 1'b0);
    step(1'b1, DATA_W'(32'hF), 4'b0101, 1'b1, 1'b1);
    idle(1'b0);
    #3;
    chk("flush2_occ", occupancy, 2'd0);
    chk("flush2_ctrl", out_ctrl, 4'b0000);

    // Mixed traffic pattern, checked by the scoreboard every cycle.
    for (int k = 0; k < 10; k++)
      step(iv_pat[k], DATA_W'(100 + k), 4'(k), or_pat[k], 1'b0);
    repeat (3) idle(1'b1);

    // Reset asserted mid-stream while a beat is held.
    step(1'b1, DATA_W'(32'h99), 4'b1001, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_ctrl", out_ctrl, '0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    in_data   = DATA_W'(32'h77);
    in_ctrl   = 4'b0111;
    out_ready = 1'b0;
    idle(1'b0);
    #3;
    chk("post_rst_accept", out_data, 32'h77);
    chk("post_rst_ctrl", out_ctrl, 4'b0111);
    repeat (3) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
